// File: rtl/alu_sequencer.sv
// Command front-end for the shared-bus ALU: loads x then y, collects a one- or two-word
// result, and returns it through a single-entry buffer, with a watchdog on each result wait.
module alu_sequencer #(
  parameter int unsigned w       = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [1:0]     cmd_op,
  input  logic [w-1:0]   cmd_x,
  input  logic [w-1:0]   cmd_y,
  output logic [w-1:0]   alu_in,
  output logic [1:0]     alu_op,
  output logic           alu_valid,
  input  logic [w-1:0]   alu_o,
  input  logic           alu_ready,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [2*w-1:0] res_data,
  output logic           res_err,
  output logic           busy
);

  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_X,
    LOAD_Y,
    WAIT_HI,
    WAIT_LO,
    RESP
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [w-1:0]  x_q, x_d;
  logic [w-1:0]  y_q, y_d;
  logic [w-1:0]  hi_q, hi_d;
  logic [w-1:0]  lo_q, lo_d;
  logic          err_q, err_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [w-1:0]  alu_in_q, alu_in_d;
  logic [1:0]    alu_op_q, alu_op_d;
  logic          alu_valid_q, alu_valid_d;
  logic [TW-1:0] timer_inc;
  logic          timed_out;

  assign timer_inc = (timer_q == T_LAST) ? timer_q : timer_q + TW'(1);
  assign timed_out = (timer_q == T_LAST);

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    x_d         = x_q;
    y_d         = y_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    err_d       = err_q;
    timer_d     = '0;
    alu_in_d    = '0;
    alu_op_d    = '0;
    alu_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          x_d     = cmd_x;
          y_d     = cmd_y;
          err_d   = 1'b0;
          state_d = LOAD_X;
        end
      end
      LOAD_X: state_d = LOAD_Y;
      LOAD_Y: begin
        // hi pre-cleared so one-word ops return a zero-extended result
        hi_d    = '0;
        lo_d    = '0;
        err_d   = 1'b0;
        state_d = op_q[1] ? WAIT_HI : WAIT_LO;
      end
      WAIT_HI: begin
        if (alu_ready) begin
          hi_d    = alu_o;
          state_d = WAIT_LO;
        end else if (timed_out) begin
          err_d   = 1'b1;
          hi_d    = '0;
          lo_d    = '0;
          state_d = RESP;
        end else begin
          timer_d = timer_inc;
        end
      end
      WAIT_LO: begin
        if (alu_ready) begin
          lo_d    = alu_o;
          state_d = RESP;
        end else if (timed_out) begin
          err_d   = 1'b1;
          hi_d    = '0;
          lo_d    = '0;
          state_d = RESP;
        end else begin
          timer_d = timer_inc;
        end
      end
      RESP: begin
        if (res_ready) begin
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // ALU bus is decoded from the next state so it leaves a register in step with the FSM
    alu_valid_d = (state_d == LOAD_X);
    if (state_d == LOAD_X) begin
      alu_in_d = x_d;
    end else if (state_d == LOAD_Y) begin
      alu_in_d = y_d;
    end
    if (state_d inside {LOAD_X, LOAD_Y, WAIT_HI, WAIT_LO}) begin
      alu_op_d = op_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= '0;
      x_q         <= '0;
      y_q         <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      err_q       <= 1'b0;
      timer_q     <= '0;
      alu_in_q    <= '0;
      alu_op_q    <= '0;
      alu_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      x_q         <= x_d;
      y_q         <= y_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      err_q       <= err_d;
      timer_q     <= timer_d;
      alu_in_q    <= alu_in_d;
      alu_op_q    <= alu_op_d;
      alu_valid_q <= alu_valid_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign res_valid = (state_q == RESP);
  assign res_data  = {hi_q, lo_q};
  assign res_err   = err_q;
  assign alu_in    = alu_in_q;
  assign alu_op    = alu_op_q;
  assign alu_valid = alu_valid_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: the bench plays the ALU, answers with arithmetic results after
// chosen delays, and checks every bus phase and the returned result.
module tb_alu_sequencer;

  localparam int W  = 8;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [W-1:0]  cmd_x;
  logic [W-1:0]  cmd_y;
  logic [W-1:0]  alu_in;
  logic [1:0]    alu_op;
  logic          alu_valid;
  logic [W-1:0]  alu_o;
  logic          alu_ready;
  logic          res_valid;
  logic          res_ready;
  logic [2*W-1:0] res_data;
  logic          res_err;
  logic          busy;

  int errors = 0;
  int checks = 0;

  alu_sequencer #(.w(W), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_x     (cmd_x),
    .cmd_y     (cmd_y),
    .alu_in    (alu_in),
    .alu_op    (alu_op),
    .alu_valid (alu_valid),
    .alu_o     (alu_o),
    .alu_ready (alu_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_err   (res_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Arithmetic result as {hi, lo}: div returns {remainder, quotient}
  function automatic logic [15:0] ref_res(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y);
    logic [15:0] r;
    case (op)
      2'b00:   r = {8'h00, 8'(x + y)};
      2'b01:   r = {8'h00, 8'(x - y)};
      2'b10:   r = {8'h00, x} * {8'h00, y};
      default: r = {8'(x % y), 8'(x / y)};
    endcase
    return r;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_alu_valid"}, 32'(alu_valid), 32'd0);
    chk({tag, "_alu_in"},    32'(alu_in),    32'd0);
    chk({tag, "_alu_op"},    32'(alu_op),    32'd0);
    chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    chk({tag, "_res_data"},  32'(res_data),  32'd0);
    chk({tag, "_res_err"},   32'(res_err),   32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
  endtask

  // One wait phase as seen by the ALU: strobe the word after dly cycles, or never if dly >= TO.
  task automatic wait_phase(input string tag, input logic [1:0] op, input int dly,
                            input logic [7:0] word, output bit timed_out);
    int n;
    n = (dly < TO) ? dly : TO - 1;
    for (int k = 0; k <= n; k++) begin
      chk({tag, "_in"},     32'(alu_in),    32'd0);
      chk({tag, "_op"},     32'(alu_op),    32'(op));
      chk({tag, "_valid"},  32'(alu_valid), 32'd0);
      chk({tag, "_res_v"},  32'(res_valid), 32'd0);
      alu_ready = (k == dly);
      alu_o     = (k == dly) ? word : 8'($urandom);
      tick();
    end
    alu_ready = 1'b0;
    timed_out = (dly >= TO);
  endtask

  task automatic run_txn(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y,
                         input int dhi, input int dlo, input int hold);
    logic [15:0] exp;
    logic        err_exp;
    logic [15:0] held;
    bit          to;
    exp     = ref_res(op, x, y);
    err_exp = 1'b0;
    to      = 1'b0;

    chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_x     = x;
    cmd_y     = y;
    tick();
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_x     = 8'($urandom);
    cmd_y     = 8'($urandom);
    chk("ldx_valid",     32'(alu_valid), 32'd1);
    chk("ldx_in",        32'(alu_in),    32'(x));
    chk("ldx_op",        32'(alu_op),    32'(op));
    chk("ldx_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("ldx_busy",      32'(busy),      32'd1);
    tick();
    chk("ldy_valid", 32'(alu_valid), 32'd0);
    chk("ldy_in",    32'(alu_in),    32'(y));
    chk("ldy_op",    32'(alu_op),    32'(op));
    tick();

    if (op[1]) wait_phase("whi", op, dhi, exp[15:8], to);
    if (!to)   wait_phase("wlo", op, dlo, exp[7:0], to);
    if (to) begin
      exp     = 16'h0000;
      err_exp = 1'b1;
    end

    held = res_data;
    for (int h = 0; h <= hold; h++) begin
      chk("resp_valid",     32'(res_valid), 32'd1);
      chk("resp_data",      32'(res_data),  32'(exp));
      chk("resp_err",       32'(res_err),   32'(err_exp));
      chk("resp_stable",    32'(res_data),  32'(held));
      chk("resp_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("resp_alu_valid", 32'(alu_valid), 32'd0);
      chk("resp_alu_in",    32'(alu_in),    32'd0);
      res_ready = (h == hold);
      cmd_valid = (h != hold);
      alu_ready = (h != hold);
      alu_o     = 8'($urandom);
      tick();
    end
    res_ready = 1'b0;
    cmd_valid = 1'b0;
    alu_ready = 1'b0;
    chk("post_res_valid", 32'(res_valid), 32'd0);
    chk("post_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("post_busy",      32'(busy),      32'd0);
    chk("post_alu_op",    32'(alu_op),    32'd0);
    chk("post_err",       32'(res_err),   32'd0);
  endtask

  initial begin
    logic [1:0] op;
    logic [7:0] x, y;
    int dhi, dlo;

    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_x     = '0;
    cmd_y     = '0;
    alu_o     = '0;
    alu_ready = 1'b0;
    res_ready = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Directed: add, mul, backpressure, timeout then recovery, tie at last timer value
    run_txn(2'b00, 8'h05, 8'h03, 0, 2, 0);
    run_txn(2'b10, 8'hF0, 8'h10, 1, 2, 0);
    run_txn(2'b01, 8'h03, 8'h05, 0, 0, 10);
    run_txn(2'b11, 8'h37, 8'h05, 100, 0, 1);
    run_txn(2'b11, 8'h37, 8'h05, 2, 0, 0);
    run_txn(2'b00, 8'h10, 8'h20, 0, TO - 1, 0);
    run_txn(2'b10, 8'h12, 8'h34, TO - 1, TO - 1, 0);
    run_txn(2'b10, 8'h12, 8'h34, 3, TO, 0);

    // Reset asserted while a mul waits for its high word
    cmd_valid = 1'b1;
    cmd_op    = 2'b10;
    cmd_x     = 8'h03;
    cmd_y     = 8'h04;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("midop_busy", 32'(busy), 32'd1);
    #1 rst = 1'b1;
    #1 check_reset_outputs("midop_rst");
    #1 rst = 1'b0;
    tick();
    run_txn(2'b00, 8'h01, 8'h01, 0, 0, 0);
    chk("after_rst_ref", 32'(ref_res(2'b00, 8'h01, 8'h01)), 32'h0002);

    // Random transactions with occasional timeouts
    for (int i = 0; i < 40; i++) begin
      op  = 2'($urandom);
      x   = 8'($urandom);
      y   = 8'($urandom);
      if (y == 8'h00) y = 8'h01;
      dhi = ($urandom_range(0, 7) == 0) ? 70 : $urandom_range(0, 6);
      dlo = ($urandom_range(0, 7) == 0) ? 70 : $urandom_range(0, 6);
      run_txn(op, x, y, dhi, dlo, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
